cmd_source_arbiter: RTL and testbench
=====================================

# cmd_source_arbiter

Shares the single command-word recognizer datapath between two character sources (wall keypad = channel 0, remote link = channel 1). Grants one source at a time for a whole command word, clears the recognizer before each word, forwards characters with a valid/ready handshake, and aborts words that stall or overrun. Sits between the character front-ends and the recognizer in the SmartHouse control path.

## Interface
- TIMEOUT, 255: idle cycles allowed in STREAM with no transfer before abort (1..255)
- MAX_LEN, 16: maximum characters per word, terminator included (2..255)
- TERMINATOR, 8'h2E ("."): end-of-word character, forwarded downstream
- clock  in  1  single clock, rising edge
- reset  in  1  reset is asynchronous and active-high
- req0_valid / req1_valid  in  1  source has a character
- req0_char / req1_char  in  8  ASCII character
- req0_ready / req1_ready  out  1  character accepted this cycle when valid & ready
- rec_valid  out  1  character presented to recognizer
- rec_char  out  8  character to recognizer
- rec_ready  in  1  recognizer accepts
- rec_clear  out  1  one-cycle pulse: recognizer returns to its start state
- grant  out  2  one-hot owner, 2'b00 when none
- busy  out  1  high in every state except IDLE
- abort  out  1  one-cycle pulse: word killed by timeout or overlength

## Operation
- States: IDLE, CLEAR, STREAM, RELEASE.
- IDLE: if exactly one reqN_valid, grant it; if both, grant the channel not in last_grant. last_grant resets to 1, so channel 0 wins the first tie. Next state CLEAR.
- CLEAR: rec_clear=1 for exactly this cycle; no transfers (all ready low, rec_valid low). Next state STREAM.
- STREAM: rec_valid = granted reqN_valid, rec_char = granted reqN_char, granted reqN_ready = rec_ready; non-granted ready held 0. A transfer is rec_valid & rec_ready.
  - On transfer: len increments, idle counter clears.
  - Transfer of TERMINATOR -> RELEASE, normal end.
  - Transfer making len == MAX_LEN, not TERMINATOR -> RELEASE with abort.
  - Cycle without transfer: idle counter increments; at TIMEOUT -> RELEASE with abort.
- RELEASE: grant=00, no transfers, last_grant updated to the finished channel, len and idle counter cleared. If aborting: abort=1 and rec_clear=1 in this cycle. Next state IDLE.
- Combinational outputs: rec_valid, rec_char, reqN_ready. All other outputs and state are registered.
- Counter widths: len and idle counter 8 bits, no wrap; both saturate at their limit and are cleared on exit.

## Timing
- Reset values: state IDLE, grant 00, busy 0, rec_clear 0, abort 0, rec_valid 0, rec_char 8'h00, req ready 0, last_grant 1.
- Reset mid-word: immediate return to IDLE with all outputs at reset values. Channel state is not saved. No rec_clear is issued until the next grant.
- A request seen in IDLE at edge N gives grant and rec_clear from N+1. STREAM starts at N+2, and the first transfer is possible at N+2.
- Steady state: one character per cycle while valid & rec_ready.
- Word turnaround: RELEASE (1 cycle) plus IDLE (1 cycle) plus CLEAR (1 cycle) before the next word streams.
- Simultaneous events:
  - TERMINATOR on the MAX_LEN-th transfer: normal end, no abort.
  - A transfer in the cycle the idle counter would reach TIMEOUT: the transfer wins and the counter clears.
- Requester deasserting valid while waiting for a grant: no effect; the arbiter re-evaluates each IDLE cycle.

## Structure
- Shared package smart_house_pkg holds:
  - state enum (IDLE, CLEAR, STREAM, RELEASE)
  - TERMINATOR default
  - grant encodings GRANT_NONE, GRANT_CH0, GRANT_CH1
- Sub-module word_guard_counter: owns len and the idle counter, with inputs xfer and clr, outputs overlength and timeout. The FSM and the mux stay in the top.

## Test plan
- Channel 0 only, sends "OPENWINDOW." with rec_ready=1:
  - grant=01 and rec_clear pulse on cycle 1; 11 characters pass in cycles 2..12
  - RELEASE on cycle 13, abort never asserted
- Both valid in the same IDLE cycle after reset -> channel 0 granted first. Channel 1 stays stalled (ready=0) until channel 0's terminator passes, then is granted.
- Channel 1 sends 16 characters with no "." at MAX_LEN=16 -> after the 16th transfer: abort=1, rec_clear=1, grant=00.
- Channel 0 sends "OP" then stops with TIMEOUT=4 -> abort after 4 idle cycles in STREAM, then IDLE.
- rec_ready low for 3 cycles mid-word (TIMEOUT=4) -> channel sees ready=0, no characters lost or duplicated, no abort.
- Assert reset during STREAM after 3 characters -> same cycle: grant=00, busy=0, rec_valid=0. After release, channel 1 valid -> channel 1 granted with a fresh rec_clear.

Source files
------------

// File: rtl/smart_house_pkg.sv
// Shared SmartHouse definitions: arbiter FSM states, grant encodings and
// the default end-of-word character.
package smart_house_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        STREAM  = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam logic [7:0] TERMINATOR_DEFAULT = 8'h2E;  // "."

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CH0  = 2'b01;
    localparam logic [1:0] GRANT_CH1  = 2'b10;

    // One-hot grant for a channel index (0 = keypad, 1 = remote link).
    function automatic logic [1:0] grant_of(input logic ch);
        return ch ? GRANT_CH1 : GRANT_CH0;
    endfunction

endpackage

// File: rtl/word_guard_counter.sv
// Word guard: tracks characters in the current word and consecutive
// stalled cycles. Both counters saturate and are cleared while clr is high.
// overlength / timeout are look-ahead flags for the current cycle, so the
// arbiter can leave STREAM on the very transfer (or stall) that hits a limit.
module word_guard_counter
    import smart_house_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic xfer,
    input  logic clr,
    output logic overlength,
    output logic timeout
);

    localparam logic [7:0] LEN_LIMIT  = 8'(MAX_LEN);
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT);

    logic [7:0] len_q,  len_d;
    logic [7:0] idle_q, idle_d;

    // Next counter values: transfers bump len and clear idle, stalls bump idle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        len_d  = len_q;
        idle_d = idle_q;
        if (clr) begin
            len_d  = 8'd0;
            idle_d = 8'd0;
        end else if (xfer) begin
            len_d  = (len_q == LEN_LIMIT) ? len_q : len_q + 8'd1;
            idle_d = 8'd0;
        end else begin
            idle_d = (idle_q == IDLE_LIMIT) ? idle_q : idle_q + 8'd1;
        end
    end

    // This transfer makes the word MAX_LEN long.
    assign overlength = !clr && xfer && (len_q >= LEN_LIMIT - 8'd1);
    // This stalled cycle is the TIMEOUT-th in a row.
    assign timeout    = !clr && !xfer && (idle_q >= IDLE_LIMIT - 8'd1);

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q  <= 8'd0;
            idle_q <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            len_q  <= len_d;
            idle_q <= idle_d;
        end
    end

endmodule

// File: rtl/cmd_source_arbiter.sv
// Command source arbiter: lends the single command-word recognizer to the
// wall keypad (channel 0) or the remote link (channel 1) for one whole word,
// clearing the recognizer first and aborting words that stall or overrun.
module cmd_source_arbiter
    import smart_house_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [7:0]  TERMINATOR = TERMINATOR_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    output logic       rec_valid,
    output logic [7:0] rec_char,
    input  logic       rec_ready,
    output logic       rec_clear,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;          // channel holding the recognizer
    logic       last_grant_q, last_grant_d; // channel that finished most recently
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       rec_clear_q, rec_clear_d;
    logic       abort_q, abort_d;

    logic       word_kill;
    logic       pick;
    logic       sel_valid;
    logic [7:0] sel_char;
    logic       xfer;
    logic       is_term;
    logic       overlength;
    logic       timeout;

    // On a tie the channel that did not finish last wins.
    assign pick      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign sel_valid = owner_q ? req1_valid : req0_valid;
    assign sel_char  = owner_q ? req1_char  : req0_char;
    assign xfer      = (state_q == STREAM) && sel_valid && rec_ready;
    assign is_term   = (sel_char == TERMINATOR);

    word_guard_counter #(
        .TIMEOUT (TIMEOUT),
        .MAX_LEN (MAX_LEN)
    ) u_guard (
        .clock      (clock),
        .reset      (reset),
        .xfer       (xfer),
        .clr        (state_q != STREAM),
        .overlength (overlength),
        .timeout    (timeout)
    );

    // State, owner and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= GRANT_NONE;
            busy_q       <= 1'b0;
            rec_clear_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            rec_clear_q  <= rec_clear_d;
            abort_q      <= abort_d;
        end
    end

    // Next-state: grant in IDLE, clear, stream until terminator or a guard trips.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        word_kill    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_d = pick;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                // A terminator always ends the word normally, even on the last allowed slot.
                if (xfer && is_term) begin
                    state_d = RELEASE;
                end else if (overlength || timeout) begin
                    state_d   = RELEASE;
                    word_kill = 1'b1;
                end
            end
            RELEASE: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake mux is combinational, the rest is set up for the next cycle.
    always_comb begin
        rec_valid  = 1'b0;
        rec_char   = 8'h00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == STREAM) begin
            rec_valid = sel_valid;
            rec_char  = sel_char;
            if (owner_q) begin
                req1_ready = rec_ready;
            end else begin
                req0_ready = rec_ready;
            end
        end
        grant_d     = ((state_d == CLEAR) || (state_d == STREAM)) ? grant_of(owner_d) : GRANT_NONE;
        busy_d      = (state_d != IDLE);
        abort_d     = word_kill;
        rec_clear_d = (state_d == CLEAR) || word_kill;
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign rec_clear = rec_clear_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_cmd_source_arbiter.sv
// Self-checking bench for cmd_source_arbiter: per-channel scoreboards of
// expected characters, filled as characters are presented and drained as
// the recognizer side accepts them, plus directed cycle-level checks.
module tb_cmd_source_arbiter;
    import smart_house_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_MAX_LEN = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_char,  req1_char;
    logic       req0_ready, req1_ready;
    logic       rec_valid;
    logic [7:0] rec_char;
    logic       rec_ready;
    logic       rec_clear;
    logic [1:0] grant;
    logic       busy;
    logic       abort;

    cmd_source_arbiter #(
        .TIMEOUT    (TB_TIMEOUT),
        .MAX_LEN    (TB_MAX_LEN),
        .TERMINATOR (8'h2E)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_char  (req0_char),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_char  (req1_char),
        .req1_ready (req1_ready),
        .rec_valid  (rec_valid),
        .rec_char   (rec_char),
        .rec_ready  (rec_ready),
        .rec_clear  (rec_clear),
        .grant      (grant),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int xfer_cnt   [2];
    int first_xfer [2];
    int last_xfer  [2];
    int abort_cnt      = 0;
    int both_ready_cnt = 0;
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Recognizer-side monitor: every accepted character is popped and compared.
    always @(negedge clock) begin
        int ch;
        if (!reset) begin
            if (req0_ready && req1_ready) both_ready_cnt++;
            if (abort) abort_cnt++;
            if (rec_valid && rec_ready) begin
                ch = req1_ready ? 1 : 0;
                if (ch == 1) begin
                    if (exp_q1.size() == 0) check("sb_underflow_ch1", exp_q1.size(), 1);
                    else                    check("rec_char_ch1", rec_char, exp_q1.pop_front());
                end else begin
                    if (exp_q0.size() == 0) check("sb_underflow_ch0", exp_q0.size(), 1);
                    else                    check("rec_char_ch0", rec_char, exp_q0.pop_front());
                end
                xfer_cnt[ch]++;
                if (first_xfer[ch] < 0) first_xfer[ch] = cyc;
                last_xfer[ch] = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            xfer_cnt[i]   = 0;
            first_xfer[i] = -1;
            last_xfer[i]  = -1;
        end
    endtask

    function automatic logic ready_of(input bit ch);
        return ch ? req1_ready : req0_ready;
    endfunction

    // Drive one source; optionally record the character as expected downstream.
    task automatic present(input bit ch, input logic v, input logic [7:0] c, input bit push);
        if (ch) begin
            req1_valid = v;
            req1_char  = c;
            if (push) exp_q1.push_back(c);
        end else begin
            req0_valid = v;
            req0_char  = c;
            if (push) exp_q0.push_back(c);
        end
    endtask

    // Handshaking source: holds each character until accepted (bounded wait).
    task automatic send_word(input bit ch, input string s);
        logic acc;
        for (int i = 0; i < s.len(); i++) begin
            present(ch, 1'b1, s[i], 1'b1);
            acc = 1'b0;
            for (int b = 0; b < 200 && !acc; b++) begin
                @(negedge clock);
                acc = ready_of(ch);
                @(posedge clock);
                #1;
            end
            if (!acc) begin
                check(ch ? "accept_ch1" : "accept_ch0", acc, 1);
                present(ch, 1'b0, 8'h00, 1'b0);
                return;
            end
        end
        present(ch, 1'b0, 8'h00, 1'b0);
    endtask

    // Cycle-exact word from IDLE with rec_ready held high.
    task automatic run_fixed_word(input bit ch, input string s);
        logic [1:0] g;
        int base;
        g    = ch ? 2'b10 : 2'b01;
        base = xfer_cnt[ch];
        present(ch, 1'b1, s[0], 1'b1);
        #1;
        check("w_c0_busy", busy, 0);
        tick();
        check("w_c1_grant", grant, g);
        check("w_c1_rec_clear", rec_clear, 1);
        check("w_c1_busy", busy, 1);
        check("w_c1_rec_valid", rec_valid, 0);
        check("w_c1_ready", ready_of(ch), 0);
        tick();
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) present(ch, 1'b1, s[i], 1'b1);
            #1;
            check("w_stream_ready", ready_of(ch), 1);
            check("w_stream_other_ready", ready_of(!ch), 0);
            check("w_stream_grant", grant, g);
            check("w_stream_rec_clear", rec_clear, 0);
            tick();
        end
        present(ch, 1'b0, 8'h00, 1'b0);
        check("w_rel_grant", grant, 2'b00);
        check("w_rel_busy", busy, 1);
        check("w_rel_abort", abort, 0);
        check("w_rel_rec_clear", rec_clear, 0);
        tick();
        check("w_idle_busy", busy, 0);
        check("w_xfer_count", xfer_cnt[ch] - base, s.len());
    endtask

    initial begin
        int abort_base;
        reset = 1'b1;
        req0_valid = 1'b0; req0_char = 8'h00;
        req1_valid = 1'b0; req1_char = 8'h00;
        rec_ready  = 1'b1;
        clear_stats();

        // Reset values
        tick(); tick();
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 0);
        check("rst_rec_clear", rec_clear, 0);
        check("rst_abort", abort, 0);
        check("rst_rec_valid", rec_valid, 0);
        check("rst_rec_char", rec_char, 8'h00);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        reset = 1'b0;

        // Channel 0 alone, normal word
        run_fixed_word(1'b0, "OPENWINDOW.");
        check("w1_no_abort", abort_cnt, 0);

        // Tie straight after reset: channel 0 first, channel 1 right after turnaround
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_stats();
        fork
            send_word(1'b0, "LIGHTON.");
            send_word(1'b1, "DOOR.");
        join
        tick();
        check("tie_ch0_first", 32'(first_xfer[0] < first_xfer[1]), 1);
        check("tie_gap", first_xfer[1] - last_xfer[0], 4);
        check("tie_ch0_count", xfer_cnt[0], 8);
        check("tie_ch1_count", xfer_cnt[1], 5);

        // Overlength on channel 1
        clear_stats();
        abort_base = abort_cnt;
        send_word(1'b1, "ABCDEFGHIJKLMNOP");
        check("ovl_abort", abort, 1);
        check("ovl_rec_clear", rec_clear, 1);
        check("ovl_grant", grant, 2'b00);
        check("ovl_count", xfer_cnt[1], 16);
        tick();
        check("ovl_idle_busy", busy, 0);
        check("ovl_abort_pulse", abort, 0);
        check("ovl_abort_cnt", abort_cnt - abort_base, 1);

        // Timeout on channel 0 after two characters
        clear_stats();
        send_word(1'b0, "OP");
        for (int k = 0; k < 4; k++) begin
            check("to_wait_abort", abort, 0);
            check("to_wait_grant", grant, 2'b01);
            tick();
        end
        check("to_abort", abort, 1);
        check("to_rec_clear", rec_clear, 1);
        check("to_grant", grant, 2'b00);
        tick();
        check("to_idle_busy", busy, 0);
        check("to_count", xfer_cnt[0], 2);

        // Recognizer back-pressure for three cycles mid-word
        clear_stats();
        abort_base = abort_cnt;
        fork
            send_word(1'b1, "FANON.");
            begin
                for (int b = 0; b < 50 && xfer_cnt[1] < 2; b++) tick();
                check("stall_reached", 32'(xfer_cnt[1] >= 2), 1);
                rec_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("stall_ready", req1_ready, 0);
                    tick();
                end
                rec_ready = 1'b1;
            end
        join
        tick();
        check("stall_no_abort", abort_cnt - abort_base, 0);
        check("stall_count", xfer_cnt[1], 6);
        check("stall_q_empty", exp_q1.size(), 0);

        // Reset in the middle of a word, then a fresh grant to channel 1
        clear_stats();
        present(1'b0, 1'b1, "C", 1'b1);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) present(1'b0, 1'b1, "U", 1'b1);
            if (i == 2) present(1'b0, 1'b1, "R", 1'b1);
            tick();
        end
        check("mid_count", xfer_cnt[0], 3);
        present(1'b0, 1'b1, "T", 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rec_valid", rec_valid, 0);
        check("mid_rst_ready", req0_ready, 0);
        check("mid_rst_rec_clear", rec_clear, 0);
        tick();
        present(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        run_fixed_word(1'b1, "LAMP.");

        check("final_q0_empty", exp_q0.size(), 0);
        check("final_q1_empty", exp_q1.size(), 0);
        check("final_both_ready", both_ready_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
